// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared region decode, address map and RAM pin encoding for the SRAM bridge.
package sram_bridge_pkg;

    typedef enum logic [2:0] {R_BASE, R_EXT, R_UDATA, R_USTAT, R_NONE} region_t;

    typedef struct packed {
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic       oe;
        logic [3:0] be_n;
    } ram_ctl_t;

    localparam logic [31:0] BASE_LO      = 32'h0000_0000;
    localparam logic [31:0] EXT_LO       = 32'h0040_0000;
    localparam logic [31:0] RAM_BYTES    = 32'h0040_0000;
    localparam logic [31:0] UART_DATA_PA = 32'h1FD0_03F8;
    localparam logic [31:0] UART_STAT_PA = 32'h1FD0_03FC;
    localparam logic [31:0] KSEG_MASK    = 32'h1FFF_FFFF;

    // Subtract-then-compare keeps the range check free of an always-true lower bound.
    function automatic region_t decode(input logic [31:0] pa);
        return (pa - BASE_LO < RAM_BYTES) ? R_BASE :
               (pa - EXT_LO < RAM_BYTES)  ? R_EXT  :
               (pa == UART_DATA_PA)       ? R_UDATA :
               (pa == UART_STAT_PA)       ? R_USTAT : R_NONE;
    endfunction

    function automatic ram_ctl_t ram_ctl(input logic act, input logic we, input logic [3:0] be);
        return '{ce_n: !act, oe_n: !(act && !we), we_n: !(act && we), oe: act && we,
                 be_n: !act ? 4'hF : we ? ~be : 4'h0};
    endfunction

endpackage

// File: rtl/sram_bridge_uart_buf.sv
// uart_buf: one-entry TX and RX holding buffers with ready/valid handshakes toward the UART.
module uart_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_wr,
    input  logic [7:0] tx_wdata,
    input  logic       tx_ready,
    input  logic       rx_rd,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_stall,
    output logic       tx_empty,
    output logic       rx_ack,
    output logic       rx_full,
    output logic [7:0] rx_byte
);

    logic tx_accept, capture;

    // A drain in the same cycle frees the slot, so the write goes in without stalling.
    assign tx_accept = tx_wr & (~tx_valid | tx_ready);
    assign tx_stall  = tx_wr & tx_valid & ~tx_ready;
    assign tx_empty  = ~tx_valid;
    assign capture   = rx_valid & ~rx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rx_full  <= 1'b0;
            rx_byte  <= '0;
            rx_ack   <= 1'b0;
        end else begin
            tx_valid <= tx_accept | (tx_valid & ~tx_ready);
            if (tx_accept) tx_data <= tx_wdata;
            rx_full  <= capture | (rx_full & ~rx_rd);
            if (capture) rx_byte <= rx_data;
            rx_ack   <= capture;
        end
    end

endmodule

// File: rtl/sram_bridge.sv
// sram_bridge: maps the core's fetch and data SRAM ports onto base RAM, ext RAM and UART,
// with kseg translation, base-RAM conflict stalls and one-cycle read return.
module sram_bridge
    import sram_bridge_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        SRAM_INST_CE,
    input  logic        SRAM_INST_WE,
    input  logic [3:0]  SRAM_INST_BE,
    input  logic [31:0] SRAM_INST_VADDR,
    input  logic [31:0] SRAM_INST_WDATA,
    input  logic        SRAM_DATA_CE,
    input  logic        SRAM_DATA_WE,
    input  logic [3:0]  SRAM_DATA_BE,
    input  logic [31:0] SRAM_DATA_VADDR,
    input  logic [31:0] SRAM_DATA_WDATA,
    output logic [31:0] INST,
    output logic [31:0] DATA,
    output logic        STALL_STR,
    output logic [19:0] BASE_RAM_ADDR,
    output logic [31:0] BASE_RAM_WDATA,
    input  logic [31:0] BASE_RAM_RDATA,
    output logic        BASE_RAM_OE,
    output logic        BASE_RAM_CE_N,
    output logic        BASE_RAM_OE_N,
    output logic        BASE_RAM_WE_N,
    output logic [3:0]  BASE_RAM_BE_N,
    output logic [19:0] EXT_RAM_ADDR,
    output logic [31:0] EXT_RAM_WDATA,
    input  logic [31:0] EXT_RAM_RDATA,
    output logic        EXT_RAM_OE,
    output logic        EXT_RAM_CE_N,
    output logic        EXT_RAM_OE_N,
    output logic        EXT_RAM_WE_N,
    output logic [3:0]  EXT_RAM_BE_N,
    output logic        UART_TX_VALID,
    output logic [7:0]  UART_TX_DATA,
    input  logic        UART_TX_READY,
    input  logic        UART_RX_VALID,
    input  logic [7:0]  UART_RX_DATA,
    output logic        UART_RX_ACK
);

    logic [31:0] i_pa, d_pa, uart_q;
    logic        i_ce, d_ce, conflict, i_fetch, d_rd, tx_wr, rx_rd, tx_stall, tx_empty, rx_full;
    logic [7:0]  rx_byte;
    region_t     i_reg, d_reg, inst_src, data_src;

    // Requests are masked while in reset so every pin and the stall drop immediately.
    assign i_ce  = SRAM_INST_CE & RST;
    assign d_ce  = SRAM_DATA_CE & RST;
    assign i_pa  = SRAM_INST_VADDR & KSEG_MASK;
    assign d_pa  = SRAM_DATA_VADDR & KSEG_MASK;
    assign i_reg = decode(i_pa);
    assign d_reg = decode(d_pa);

    assign conflict = d_ce && d_reg == R_BASE;
    assign i_fetch  = i_ce && i_reg == R_BASE && !conflict;
    assign d_rd     = d_ce && !SRAM_DATA_WE;
    assign tx_wr    = d_ce && SRAM_DATA_WE && d_reg == R_UDATA;
    assign rx_rd    = d_rd && d_reg == R_UDATA;
    assign STALL_STR = conflict | tx_stall;

    assign {BASE_RAM_CE_N, BASE_RAM_OE_N, BASE_RAM_WE_N, BASE_RAM_OE, BASE_RAM_BE_N} =
        ram_ctl(conflict | i_fetch, conflict ? SRAM_DATA_WE : SRAM_INST_WE,
                conflict ? SRAM_DATA_BE : SRAM_INST_BE);
    assign BASE_RAM_ADDR  = conflict ? d_pa[21:2] : i_pa[21:2];
    assign BASE_RAM_WDATA = conflict ? SRAM_DATA_WDATA : SRAM_INST_WDATA;

    assign {EXT_RAM_CE_N, EXT_RAM_OE_N, EXT_RAM_WE_N, EXT_RAM_OE, EXT_RAM_BE_N} =
        ram_ctl(d_ce && d_reg == R_EXT, SRAM_DATA_WE, SRAM_DATA_BE);
    assign EXT_RAM_ADDR  = d_pa[21:2];
    assign EXT_RAM_WDATA = SRAM_DATA_WDATA;

    uart_buf u_uart (
        .clk      (CLK),
        .rst_n    (RST),
        .tx_wr    (tx_wr),
        .tx_wdata (SRAM_DATA_WDATA[7:0]),
        .tx_ready (UART_TX_READY),
        .rx_rd    (rx_rd),
        .rx_valid (UART_RX_VALID),
        .rx_data  (UART_RX_DATA),
        .tx_valid (UART_TX_VALID),
        .tx_data  (UART_TX_DATA),
        .tx_stall (tx_stall),
        .tx_empty (tx_empty),
        .rx_ack   (UART_RX_ACK),
        .rx_full  (rx_full),
        .rx_byte  (rx_byte)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inst_src <= R_NONE;
            data_src <= R_NONE;
            uart_q   <= '0;
        end else begin
            inst_src <= (i_fetch && !SRAM_INST_WE) ? R_BASE : R_NONE;
            data_src <= d_rd ? d_reg : R_NONE;
            uart_q   <= d_reg == R_USTAT ? {30'h0, rx_full, tx_empty}
                                         : {24'h0, rx_full ? rx_byte : 8'h0};
        end
    end

    assign INST = inst_src == R_BASE ? BASE_RAM_RDATA : '0;
    assign DATA = data_src == R_BASE ? BASE_RAM_RDATA :
                  data_src == R_EXT  ? EXT_RAM_RDATA  :
                  (data_src == R_UDATA || data_src == R_USTAT) ? uart_q : '0;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed vector table plus hand sequences for UART and reset behaviour.
module tb_sram_bridge;

    logic        CLK = 1'b0, RST = 1'b0;
    logic        SRAM_INST_CE = 1'b0, SRAM_INST_WE = 1'b0;
    logic [3:0]  SRAM_INST_BE = 4'hF;
    logic [31:0] SRAM_INST_VADDR = '0, SRAM_INST_WDATA = '0;
    logic        SRAM_DATA_CE = 1'b0, SRAM_DATA_WE = 1'b0;
    logic [3:0]  SRAM_DATA_BE = 4'h0;
    logic [31:0] SRAM_DATA_VADDR = '0, SRAM_DATA_WDATA = '0;
    logic [31:0] INST, DATA;
    logic        STALL_STR;
    logic [19:0] BASE_RAM_ADDR, EXT_RAM_ADDR;
    logic [31:0] BASE_RAM_WDATA, EXT_RAM_WDATA;
    logic [31:0] BASE_RAM_RDATA = '0, EXT_RAM_RDATA = '0;
    logic        BASE_RAM_OE, BASE_RAM_CE_N, BASE_RAM_OE_N, BASE_RAM_WE_N;
    logic        EXT_RAM_OE, EXT_RAM_CE_N, EXT_RAM_OE_N, EXT_RAM_WE_N;
    logic [3:0]  BASE_RAM_BE_N, EXT_RAM_BE_N;
    logic        UART_TX_VALID, UART_TX_READY = 1'b0, UART_RX_VALID = 1'b0, UART_RX_ACK;
    logic [7:0]  UART_TX_DATA, UART_RX_DATA = '0;

    int n_cmp = 0, n_err = 0;

    sram_bridge dut (
        .CLK(CLK), .RST(RST),
        .SRAM_INST_CE(SRAM_INST_CE), .SRAM_INST_WE(SRAM_INST_WE), .SRAM_INST_BE(SRAM_INST_BE),
        .SRAM_INST_VADDR(SRAM_INST_VADDR), .SRAM_INST_WDATA(SRAM_INST_WDATA),
        .SRAM_DATA_CE(SRAM_DATA_CE), .SRAM_DATA_WE(SRAM_DATA_WE), .SRAM_DATA_BE(SRAM_DATA_BE),
        .SRAM_DATA_VADDR(SRAM_DATA_VADDR), .SRAM_DATA_WDATA(SRAM_DATA_WDATA),
        .INST(INST), .DATA(DATA), .STALL_STR(STALL_STR),
        .BASE_RAM_ADDR(BASE_RAM_ADDR), .BASE_RAM_WDATA(BASE_RAM_WDATA), .BASE_RAM_RDATA(BASE_RAM_RDATA),
        .BASE_RAM_OE(BASE_RAM_OE), .BASE_RAM_CE_N(BASE_RAM_CE_N), .BASE_RAM_OE_N(BASE_RAM_OE_N),
        .BASE_RAM_WE_N(BASE_RAM_WE_N), .BASE_RAM_BE_N(BASE_RAM_BE_N),
        .EXT_RAM_ADDR(EXT_RAM_ADDR), .EXT_RAM_WDATA(EXT_RAM_WDATA), .EXT_RAM_RDATA(EXT_RAM_RDATA),
        .EXT_RAM_OE(EXT_RAM_OE), .EXT_RAM_CE_N(EXT_RAM_CE_N), .EXT_RAM_OE_N(EXT_RAM_OE_N),
        .EXT_RAM_WE_N(EXT_RAM_WE_N), .EXT_RAM_BE_N(EXT_RAM_BE_N),
        .UART_TX_VALID(UART_TX_VALID), .UART_TX_DATA(UART_TX_DATA), .UART_TX_READY(UART_TX_READY),
        .UART_RX_VALID(UART_RX_VALID), .UART_RX_DATA(UART_RX_DATA), .UART_RX_ACK(UART_RX_ACK)
    );

    always #5 CLK = ~CLK;

    // Packed pin view {ce_n, oe_n, we_n, oe, be_n}: idle 8'hEF, read 8'h20, write {4'b0101, ~be}.
    logic [7:0] b_ctl, e_ctl;
    assign b_ctl = {BASE_RAM_CE_N, BASE_RAM_OE_N, BASE_RAM_WE_N, BASE_RAM_OE, BASE_RAM_BE_N};
    assign e_ctl = {EXT_RAM_CE_N, EXT_RAM_OE_N, EXT_RAM_WE_N, EXT_RAM_OE, EXT_RAM_BE_N};

    typedef struct {
        logic        i_ce;
        logic [31:0] i_va;
        logic        d_ce, d_we;
        logic [3:0]  d_be;
        logic [31:0] d_va, d_wd, b_rd, e_rd;
        logic [19:0] b_addr, e_addr;
        logic [7:0]  b_ctl, e_ctl;
        logic        stall;
        logic [31:0] inst, data;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic data_req(input logic ce, input logic we, input logic [3:0] be,
                            input logic [31:0] va, input logic [31:0] wd);
        SRAM_DATA_CE = ce; SRAM_DATA_WE = we; SRAM_DATA_BE = be;
        SRAM_DATA_VADDR = va; SRAM_DATA_WDATA = wd;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h2408_0001, 32'h0,
                     20'h00001, 20'h0, 8'h20, 8'hEF, 1'b0, 32'h2408_0001, 32'h0};
        vecs[1]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 4'hF, 32'h8040_0010, 32'h0, 32'h1111_1111, 32'h2222_2222,
                     20'h00002, 20'h00004, 8'h20, 8'h20, 1'b0, 32'h1111_1111, 32'h2222_2222};
        vecs[2]  = '{1'b1, 32'h8000_000C, 1'b1, 1'b1, 4'b0011, 32'h8000_0100, 32'hDEAD_BEEF, 32'h9999_9999, 32'h0,
                     20'h00040, 20'h0, 8'h5C, 8'hEF, 1'b1, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0010, 1'b1, 1'b0, 4'hF, 32'hA000_0200, 32'h0, 32'h3333_3333, 32'h0,
                     20'h00080, 20'h0, 8'h20, 8'hEF, 1'b1, 32'h0, 32'h3333_3333};
        vecs[4]  = '{1'b1, 32'h9000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h4444_4444, 32'h0,
                     20'h0, 20'h0, 8'hEF, 8'hEF, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 32'h8000_0014, 1'b1, 1'b0, 4'hF, 32'h8100_0000, 32'h0, 32'h5555_5555, 32'h0,
                     20'h00005, 20'h0, 8'h20, 8'hEF, 1'b0, 32'h5555_5555, 32'h0};
        vecs[6]  = '{1'b1, 32'h8000_0018, 1'b1, 1'b1, 4'hF, 32'h8040_0020, 32'h1234_5678, 32'h6666_6666, 32'h7777_7777,
                     20'h00006, 20'h00008, 8'h20, 8'h50, 1'b0, 32'h6666_6666, 32'h0};
        vecs[7]  = '{1'b1, 32'h8000_001C, 1'b1, 1'b0, 4'hF, 32'h803F_FFFC, 32'h0, 32'h8888_8888, 32'h0,
                     20'hFFFFF, 20'h0, 8'h20, 8'hEF, 1'b1, 32'h0, 32'h8888_8888};
        vecs[8]  = '{1'b1, 32'h8000_0020, 1'b1, 1'b0, 4'hF, 32'h8040_0000, 32'h0, 32'h0000_0001, 32'h0000_0002,
                     20'h00008, 20'h00000, 8'h20, 8'h20, 1'b0, 32'h1, 32'h2};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h807F_FFFC, 32'h0, 32'h0, 32'hABCD_0123,
                     20'h0, 20'hFFFFF, 8'hEF, 8'h20, 1'b0, 32'h0, 32'hABCD_0123};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8080_0000, 32'h0, 32'h0, 32'h5,
                     20'h0, 20'h0, 8'hEF, 8'hEF, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0,
                     20'h00001, 20'h0, 8'h20, 8'hEF, 1'b0, 32'hCAFE_F00D, 32'h0};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1357_9BDF, 32'h2468_ACE0,
                     20'h0, 20'h0, 8'hEF, 8'hEF, 1'b0, 32'h0, 32'h0};

        // Reset held with a conflicting store presented: everything must stay quiet.
        SRAM_INST_CE = 1'b1; SRAM_INST_VADDR = 32'h8000_0000;
        data_req(1'b1, 1'b1, 4'hF, 32'h8000_0000, 32'h1);
        UART_RX_VALID = 1'b0;
        step();
        step();
        chk("rst_stall", {31'h0, STALL_STR}, 32'h0);
        chk("rst_base_ctl", {24'h0, b_ctl}, 32'hEF);
        chk("rst_ext_ctl", {24'h0, e_ctl}, 32'hEF);
        chk("rst_inst", INST, 32'h0);
        chk("rst_data", DATA, 32'h0);
        chk("rst_tx_valid", {31'h0, UART_TX_VALID}, 32'h0);
        chk("rst_rx_ack", {31'h0, UART_RX_ACK}, 32'h0);
        SRAM_INST_CE = 1'b0;
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        RST = 1'b1;
        step();

        for (int k = 0; k < 13; k++) begin
            SRAM_INST_CE = vecs[k].i_ce; SRAM_INST_VADDR = vecs[k].i_va;
            data_req(vecs[k].d_ce, vecs[k].d_we, vecs[k].d_be, vecs[k].d_va, vecs[k].d_wd);
            BASE_RAM_RDATA = vecs[k].b_rd; EXT_RAM_RDATA = vecs[k].e_rd;
            #1;
            chk($sformatf("v%0d_base_ctl", k), {24'h0, b_ctl}, {24'h0, vecs[k].b_ctl});
            chk($sformatf("v%0d_ext_ctl", k), {24'h0, e_ctl}, {24'h0, vecs[k].e_ctl});
            chk($sformatf("v%0d_stall", k), {31'h0, STALL_STR}, {31'h0, vecs[k].stall});
            if (!vecs[k].b_ctl[7])
                chk($sformatf("v%0d_base_addr", k), {12'h0, BASE_RAM_ADDR}, {12'h0, vecs[k].b_addr});
            if (!vecs[k].e_ctl[7])
                chk($sformatf("v%0d_ext_addr", k), {12'h0, EXT_RAM_ADDR}, {12'h0, vecs[k].e_addr});
            step();
            chk($sformatf("v%0d_inst", k), INST, vecs[k].inst);
            chk($sformatf("v%0d_data", k), DATA, vecs[k].data);
        end
        SRAM_INST_CE = 1'b0;
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // TX: 'A' accepted, 'B' stalls while READY is low, then both emerge in order.
        UART_TX_READY = 1'b0;
        data_req(1'b1, 1'b1, 4'hF, 32'hBFD0_03F8, 32'h41);
        #1 chk("tx_a_stall", {31'h0, STALL_STR}, 32'h0);
        step();
        chk("tx_a_valid", {31'h0, UART_TX_VALID}, 32'h1);
        chk("tx_a_data", {24'h0, UART_TX_DATA}, 32'h41);
        SRAM_DATA_WDATA = 32'h42;
        #1 chk("tx_b_stall1", {31'h0, STALL_STR}, 32'h1);
        step();
        #1 chk("tx_b_stall2", {31'h0, STALL_STR}, 32'h1);
        chk("tx_a_hold", {24'h0, UART_TX_DATA}, 32'h41);
        step();
        UART_TX_READY = 1'b1;
        #1 chk("tx_b_accept", {31'h0, STALL_STR}, 32'h0);
        step();
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        UART_TX_READY = 1'b0;
        chk("tx_b_valid", {31'h0, UART_TX_VALID}, 32'h1);
        chk("tx_b_data", {24'h0, UART_TX_DATA}, 32'h42);
        step();
        UART_TX_READY = 1'b1;
        step();
        UART_TX_READY = 1'b0;
        chk("tx_drained", {31'h0, UART_TX_VALID}, 32'h0);

        // RX: capture, status, read, status after read, empty read.
        UART_RX_VALID = 1'b1; UART_RX_DATA = 8'h5A;
        step();
        chk("rx_ack", {31'h0, UART_RX_ACK}, 32'h1);
        UART_RX_VALID = 1'b0;
        data_req(1'b1, 1'b0, 4'hF, 32'hBFD0_03FC, 32'h0);
        step();
        chk("ustat_full", DATA, 32'h3);
        chk("rx_ack_pulse", {31'h0, UART_RX_ACK}, 32'h0);
        SRAM_DATA_VADDR = 32'hBFD0_03F8;
        step();
        chk("udata_read", DATA, 32'h5A);
        SRAM_DATA_VADDR = 32'hBFD0_03FC;
        step();
        chk("ustat_empty", DATA, 32'h1);
        SRAM_DATA_VADDR = 32'hBFD0_03F8;
        step();
        chk("udata_empty", DATA, 32'h0);

        // RX: new byte arrives while a full register is being read.
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        UART_RX_VALID = 1'b1; UART_RX_DATA = 8'hC3;
        step();
        chk("rx_ack_c3", {31'h0, UART_RX_ACK}, 32'h1);
        UART_RX_DATA = 8'h77;
        data_req(1'b1, 1'b0, 4'hF, 32'hBFD0_03F8, 32'h0);
        step();
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rx_old_byte", DATA, 32'hC3);
        chk("rx_no_capture", {31'h0, UART_RX_ACK}, 32'h0);
        step();
        chk("rx_ack_77", {31'h0, UART_RX_ACK}, 32'h1);
        UART_RX_VALID = 1'b0;
        data_req(1'b1, 1'b0, 4'hF, 32'hBFD0_03F8, 32'h0);
        step();
        chk("rx_new_byte", DATA, 32'h77);

        // Reset asserted in the middle of a conflicting store with a TX byte pending.
        data_req(1'b1, 1'b1, 4'hF, 32'hBFD0_03F8, 32'h55);
        step();
        chk("pend_tx_valid", {31'h0, UART_TX_VALID}, 32'h1);
        SRAM_INST_CE = 1'b1; SRAM_INST_VADDR = 32'h8000_0004;
        data_req(1'b1, 1'b0, 4'hF, 32'h8040_0010, 32'h0);
        BASE_RAM_RDATA = 32'h0000_1234; EXT_RAM_RDATA = 32'h0000_5678;
        step();
        chk("pre_rst_inst", INST, 32'h1234);
        chk("pre_rst_data", DATA, 32'h5678);
        data_req(1'b1, 1'b1, 4'b0011, 32'h8000_0100, 32'hA5A5_A5A5);
        #1;
        chk("store_stall", {31'h0, STALL_STR}, 32'h1);
        chk("store_ctl", {24'h0, b_ctl}, 32'h5C);
        chk("store_wdata", BASE_RAM_WDATA, 32'hA5A5_A5A5);
        RST = 1'b0;
        #1;
        chk("mid_rst_base_ctl", {24'h0, b_ctl}, 32'hEF);
        chk("mid_rst_ext_ctl", {24'h0, e_ctl}, 32'hEF);
        chk("mid_rst_stall", {31'h0, STALL_STR}, 32'h0);
        chk("mid_rst_inst", INST, 32'h0);
        chk("mid_rst_data", DATA, 32'h0);
        chk("mid_rst_tx_valid", {31'h0, UART_TX_VALID}, 32'h0);
        step();
        SRAM_INST_CE = 1'b0;
        data_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        RST = 1'b1;
        step();
        chk("tx_abandoned", {31'h0, UART_TX_VALID}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Bridges the core's two virtual-address SRAM ports (instruction fetch and EX-stage data access) onto the board's base RAM, ext RAM and UART. It performs kseg0/kseg1 address translation and address decode, and returns read data one cycle after the request. It detects the structural conflict when a data access targets base RAM and raises the core's `STALL_STR` input. It sits directly between the core top and the board pins.

## Interface
- `BASE_LO`, 32'h0000_0000: physical base-RAM start (4 MiB).
- `EXT_LO`, 32'h0040_0000: physical ext-RAM start (4 MiB).
- `UART_DATA_PA`, 32'h1FD0_03F8: UART data register.
- `UART_STAT_PA`, 32'h1FD0_03FC: UART status register.
- `CLK  in  1`: single clock.
- `RST  in  1`: reset, asynchronous, active-low.
- `SRAM_INST_CE/WE  in  1`, `SRAM_INST_BE  in  4`, `SRAM_INST_VADDR/WDATA  in  32`: fetch request.
- `SRAM_DATA_CE/WE  in  1`, `SRAM_DATA_BE  in  4`, `SRAM_DATA_VADDR/WDATA  in  32`: data request.
- `INST  out  32`: fetch read data.
- `DATA  out  32`: load read data.
- `STALL_STR  out  1`: structural stall request to the core.
- `BASE_RAM_ADDR  out  20`, `BASE_RAM_WDATA  out  32`, `BASE_RAM_RDATA  in  32`, `BASE_RAM_OE  out  1` (tristate enable), `BASE_RAM_CE_N/OE_N/WE_N  out  1`, `BASE_RAM_BE_N  out  4`: base RAM pins.
- `EXT_RAM_*`: the same set of pins, for ext RAM.
- `UART_TX_VALID  out  1`, `UART_TX_DATA  out  8`, `UART_TX_READY  in  1`: transmit handshake.
- `UART_RX_VALID  in  1`, `UART_RX_DATA  in  8`, `UART_RX_ACK  out  1`: receive handshake.

## Operation
- **Translation:** PA = VADDR & 32'h1FFF_FFFF. RAM word address = PA[21:2].
- **Decode** for each request:
  - BASE if PA in [BASE_LO, BASE_LO+4M).
  - EXT if PA in [EXT_LO, EXT_LO+4M).
  - UDATA if PA == UART_DATA_PA; USTAT if PA == UART_STAT_PA.
  - NONE otherwise.
- **Fetch:** always targets base RAM. A fetch to a non-BASE region returns 0.
- **Conflict:** a data request with CE=1 and region BASE owns base RAM that cycle.
  - `STALL_STR` = 1, combinational, in that cycle only.
  - The fetch is dropped and `INST` in the next cycle is 32'h0.
- **Data to EXT:** EXT RAM is driven with the data request. Fetch proceeds in parallel on base RAM.
- **RAM writes:** WE_N=0, OE_N=1, BE_N=~BE, `*_OE`=1, WDATA passed through.
- **RAM reads:** OE_N=0, WE_N=1, BE_N=4'h0, `*_OE`=0.
- **Idle RAM:** CE_N=OE_N=WE_N=1, BE_N=4'hF.
- **UART TX:** a data write to UDATA while the TX buffer is empty loads WDATA[7:0] into a 1-entry TX buffer. `UART_TX_VALID` holds until `UART_TX_READY`.
  - A write while the buffer is full asserts `STALL_STR` until the buffer drains. No byte is lost.
- **UART RX:** a 1-entry RX holding register, with a valid flag, captures `UART_RX_DATA` when `UART_RX_VALID` is high and the register is empty. `UART_RX_ACK` pulses 1 cycle on capture.
  - A read of UDATA returns {24'h0, byte} and clears the flag next edge.
  - If the register is empty, a UDATA read returns 0.
- **USTAT read:** returns {30'h0, rx_valid, tx_empty}.
- **NONE region:** reads return 0; writes are dropped.
- **Read-source registers:** `inst_src` (BASE/ZERO) and `data_src` (BASE/EXT/UDATA/USTAT/ZERO) are latched each edge. UART read values are latched with `data_src`.
- **Output mux:** `INST`/`DATA` are combinational muxes of RAM RDATA or the latched values, selected by the registered source.

## Timing
- Request in cycle N → RAM pins driven combinationally in N. Read data valid on `INST`/`DATA` in N+1.
- A base-RAM conflict costs exactly 1 stall cycle per data access. Back-to-back conflicting accesses stall each cycle.
- Simultaneous TX drain and new TX write in the same cycle: the write is accepted with no stall.
- Simultaneous RX capture and UDATA read of a full register: the read returns the old byte. The new byte is captured on the edge the flag clears, i.e. the next cycle.
- **Reset (RST=0, async):**
  - `inst_src`/`data_src` = ZERO, so `INST`/`DATA` = 0.
  - TX/RX buffers empty; `UART_TX_VALID`=0, `UART_RX_ACK`=0, `STALL_STR`=0.
  - All RAM control outputs inactive.
- Reset mid-TX abandons the pending byte.

## Structure
- **Shared package entries:** region enum (BASE, EXT, UDATA, USTAT, NONE), address constants, and the KSEG mask.
- **Sub-module `uart_buf`:** the TX/RX one-entry buffers and the handshake logic.
- The top contains decode, conflict logic, pin drive, and the read-source registers.

## Test plan
- Fetch VADDR 32'h8000_0004 with base RAM returning 32'h2408_0001 → `BASE_RAM_ADDR`=20'h00001, `INST`=32'h2408_0001 the next cycle, `STALL_STR`=0.
- Load from 32'h8040_0010 concurrent with a fetch → `EXT_RAM_ADDR`=20'h00004 and `BASE_RAM_ADDR` from the PC; both read data returned in N+1; no stall.
- Store BE=4'b0011 to 32'h8000_0100 during a fetch → `STALL_STR`=1 for one cycle, `BASE_RAM_WE_N`=0, `BE_N`=4'b1100, `INST`=0 in N+1.
- Two UDATA writes 'A', 'B' with `UART_TX_READY` held 0 for 3 cycles → the second write stalls until READY; TX emits 8'h41 then 8'h42.
- `UART_RX_VALID` with 8'h5A, then read USTAT → 32'h3. Read UDATA → 32'h5A. Read USTAT again → 32'h1.
- Assert RST low mid store → all RAM controls go inactive immediately, `INST`=`DATA`=0.
